// File: rtl/aexm_pkg.sv
// rtl/aexm_pkg.sv - shared types for the aexm forwarding scoreboard
//
// Purpose: instruction-kind encoding, multi-cycle FSM states and the
// scoreboard slot record used by aexm_fwd_scoreboard and aexm_fwd_match.
// Ports: none (package).
package aexm_pkg;

  typedef enum logic [1:0] {
    KIND_ALU     = 2'd0,
    KIND_LOAD    = 2'd1,
    KIND_MULTI   = 2'd2,
    KIND_NOWRITE = 2'd3
  } kind_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_t;

  // Slot rd is stored zero-extended to this width so the record type does not
  // depend on the top-level AW parameter; AW must not exceed it.
  localparam int RD_MAXW = 8;

  typedef struct packed {
    logic               valid;
    logic [RD_MAXW-1:0] rd;
    kind_t              kind;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: '0, kind: KIND_ALU};

  // A slot produces a forwardable result only if it really writes a register.
  function automatic logic isWriter(slot_t s);
    return s.valid && (s.rd != '0) && (s.kind != KIND_NOWRITE);
  endfunction

endpackage

// File: rtl/aexm_fwd_match.sv
// rtl/aexm_fwd_match.sv - priority matcher of one source operand against all slots
//
// Purpose: finds the youngest writer slot whose destination equals the operand
// address and reports either its forward select or a not-ready hazard.
// Ports:
//   srcAddr     in  AW        operand register address
//   srcUsed     in  1         operand is actually read
//   slotRd      in  DEPTH*AW  destination of each slot, slot k at [k*AW +: AW]
//   slotWriter  in  DEPTH     slot k holds a register-writing instruction
//   slotReady   in  DEPTH     slot k result is available for forwarding
//   sel         out SW        0 = register file, k = slot k-1
//   hazard      out 1         youngest match is not ready yet
module aexm_fwd_match #(
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  logic [AW-1:0]       srcAddr,
  input  logic                srcUsed,
  input  logic [DEPTH*AW-1:0] slotRd,
  input  logic [DEPTH-1:0]    slotWriter,
  input  logic [DEPTH-1:0]    slotReady,
  output logic [SW-1:0]       sel,
  output logic                hazard
);

  logic found;

  // Only the first (youngest) match decides; older copies of the same rd are
  // stale and must be ignored even when ready.
  always_comb begin
    sel    = '0;
    hazard = 1'b0;
    found  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (srcUsed && (srcAddr != '0) && !found && slotWriter[k] &&
          (slotRd[k*AW +: AW] == srcAddr)) begin
        found = 1'b1;
        if (slotReady[k]) sel = SW'(k + 1);
        else              hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aexm_fwd_scoreboard.sv
// rtl/aexm_fwd_scoreboard.sv - operand forwarding scoreboard and pipeline control
//
// Purpose: shift-register scoreboard of in-flight destinations between decode
// and execute; drives operand forward selects, load-use / multi-cycle stalls
// and squashes skipped instructions.
// Ports:
//   gclk       in  1         pipeline clock
//   grst       in  1         asynchronous active-high reset
//   d_en       in  1         pipeline advance enable
//   iss_valid  in  1         decode slot holds an instruction
//   iss_rd     in  AW        destination register, 0 = no write
//   iss_kind   in  2         ALU / LOAD / MULTI / NOWRITE
//   iss_skip   in  1         squash the issuing instruction
//   src_addr   in  NSRC*AW   source addresses, operand i at [i*AW +: AW]
//   src_used   in  NSRC      operand i is read
//   fwd_sel    out NSRC*SW   per operand: 0 = regfile, k = slot k-1 result
//   stall      out 1         hold decode, insert bubble
//   busy       out 1         multi-cycle op in progress
//   slot_rd    out DEPTH*AW  destination of each slot, 0 when invalid
module aexm_fwd_scoreboard
  import aexm_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int NSRC  = 2,
  parameter int MCYC  = 2,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  logic                gclk,
  input  logic                grst,
  input  logic                d_en,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic [1:0]          iss_kind,
  input  logic                iss_skip,
  input  logic [NSRC*AW-1:0]  src_addr,
  input  logic [NSRC-1:0]     src_used,
  output logic [NSRC*SW-1:0]  fwd_sel,
  output logic                stall,
  output logic                busy,
  output logic [DEPTH*AW-1:0] slot_rd
);

  slot_t      slots [DEPTH];
  fsm_state_t state;
  logic [3:0] cnt;

  logic [DEPTH-1:0] writer;
  logic [DEPTH-1:0] ready;
  logic [NSRC-1:0]  hazard;
  logic             issLive;
  logic             accept;
  logic             multiStart;

  always_comb begin
    slot_rd = '0;
    writer  = '0;
    ready   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot_rd[k*AW +: AW] = slots[k].valid ? slots[k].rd[AW-1:0] : '0;
      writer[k]           = isWriter(slots[k]);
      case (slots[k].kind)
        KIND_ALU:   ready[k] = 1'b1;
        KIND_LOAD:  ready[k] = (k != 0);   // load data arrives one stage late
        KIND_MULTI: ready[k] = (cnt == 4'd0);
        default:    ready[k] = 1'b1;
      endcase
    end
  end

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_match
    aexm_fwd_match #(.AW(AW), .DEPTH(DEPTH), .SW(SW)) u_match (
      .srcAddr    (src_addr[gi*AW +: AW]),
      .srcUsed    (src_used[gi]),
      .slotRd     (slot_rd),
      .slotWriter (writer),
      .slotReady  (ready),
      .sel        (fwd_sel[gi*SW +: SW]),
      .hazard     (hazard[gi])
    );
  end

  assign busy       = (state == ST_RUN);
  assign stall      = (|hazard) || busy;
  assign issLive    = iss_valid && !iss_skip;
  assign accept     = d_en && !stall;
  assign multiStart = accept && issLive && (iss_kind == KIND_MULTI);

  // Busy freezes everything; a hazard stall still drains older slots and
  // pushes a bubble so the producer moves on to a ready stage.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      for (int k = 0; k < DEPTH; k++) slots[k] <= SLOT_EMPTY;
    end else if (d_en && !busy) begin
      for (int k = DEPTH - 1; k > 0; k--) slots[k] <= slots[k-1];
      if (accept)
        slots[0] <= '{valid: issLive, rd: RD_MAXW'(iss_rd), kind: kind_t'(iss_kind)};
      else
        slots[0] <= SLOT_EMPTY;
    end
  end

  // cnt counts the remaining busy d_en cycles of the accepted multi-cycle op.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (multiStart && (MCYC > 1)) begin
            state <= ST_RUN;
            cnt   <= 4'(MCYC - 1);
          end
        end
        ST_RUN: begin
          if (d_en) begin
            if (cnt == 4'd1) begin
              state <= ST_IDLE;
              cnt   <= 4'd0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule
